// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and hex segment table for the seven-segment scanner
package seg_pkg;

  // Largest digit count the scanner supports
  localparam int MAX_DIGITS = 16;

  // Segment drive for a blanked digit (dp and g..a all off)
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Hex glyphs, entry n at [n]; bits 6..0 = g..a, active-high
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_HEX_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational hex nibble to seven-segment decoder
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Table lookup of the glyph for the nibble
  always_comb begin
    o_seg = hex_to_seg(i_hex);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with blink and decimal points
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_HALF = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dig_en,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [7:0]                segled,
  output logic [NUM_DIGITS-1:0]     DSN,
  output logic                      frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be in 1..16");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("seg_scan_ctrl: SCAN_DIV must be >= 1");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink_half
    $error("seg_scan_ctrl: BLINK_HALF must be >= 1");
  end

  logic [IDX_W-1:0]      r_idx;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BLK_W-1:0]      r_blink_cnt;
  logic                  r_blink_ph;
  logic [7:0]            r_segled;
  logic [NUM_DIGITS-1:0] r_dsn;
  logic                  r_frame_done;

  logic                  w_slot_last;
  logic                  w_idx_last;
  logic                  w_blink_wrap;
  logic                  w_blank;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg7;
  logic [IDX_W-1:0]      w_sel_pos;
  logic [NUM_DIGITS-1:0] w_dsn;

  assign w_slot_last  = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_idx_last   = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_blink_wrap = (r_blink_cnt == BLK_W'(BLINK_HALF - 1));
  assign w_nibble     = digits[{r_idx, 2'b00} +: 4];
  assign w_blank      = !dig_en[r_idx] || (blink_mask[r_idx] && r_blink_ph);
  // Digit 0 is leftmost, so slot i pulls the MSB-side select low
  assign w_sel_pos    = IDX_W'(NUM_DIGITS - 1) - r_idx;
  assign w_dsn        = ~(NUM_DIGITS'(1) << w_sel_pos);

  seg_decode u_seg_decode (
    .i_hex (w_nibble),
    .o_seg (w_seg7)
  );

  // Scan position, slot divider and blink phase; disable parks everything at digit 0, unblinked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_div_cnt   <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (!en) begin
      r_idx       <= '0;
      r_div_cnt   <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else begin
      r_div_cnt <= w_slot_last ? '0 : r_div_cnt + 1'b1;
      if (w_slot_last) begin
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
      if (w_blink_wrap) begin
        r_blink_ph <= ~r_blink_ph;
      end
    end
  end

  // Registered drive of the current slot's pattern and end-of-frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segled     <= SEG_BLANK;
      r_dsn        <= '1;
      r_frame_done <= 1'b0;
    end else if (!en) begin
      r_segled     <= SEG_BLANK;
      r_dsn        <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_segled     <= w_blank ? SEG_BLANK : {dp_mask[r_idx], w_seg7};
      r_dsn        <= w_dsn;
      r_frame_done <= w_slot_last && w_idx_last;
    end
  end

  assign segled     = r_segled;
  assign DSN        = r_dsn;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl (SCAN_DIV=1 and SCAN_DIV=4 instances)
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] digits;
  logic [7:0]  dig_en;
  logic [7:0]  blink_mask;
  logic [7:0]  dp_mask;

  logic [7:0]  seg_a, dsn_a, seg_b, dsn_b;
  logic        fd_a, fd_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] seg_a;
    logic [7:0] dsn_a;
    logic       fd_a;
    logic [7:0] seg_b;
    logic [7:0] dsn_b;
    logic       fd_b;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] hex_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] h_dsn [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] h_seg [8] = '{8'h06, 8'h3F, 8'h3F, 8'h3F, 8'h6D, 8'h5B, 8'h3F, 8'h4F};
  logic [31:0] mid_tbl [8] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                               32'h0F0F0F0F, 32'hA5A5A5A5, 32'h3C3C3C3C, 32'hDEADBEEF};

  seg_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(1), .BLINK_HALF(8)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dig_en(dig_en),
    .blink_mask(blink_mask), .dp_mask(dp_mask),
    .segled(seg_a), .DSN(dsn_a), .frame_done(fd_a)
  );

  seg_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4), .BLINK_HALF(500)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dig_en(dig_en),
    .blink_mask(blink_mask), .dp_mask(dp_mask),
    .segled(seg_b), .DSN(dsn_b), .frame_done(fd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_seg(input int idx, input bit ph);
    logic [3:0] nib;
    nib = digits[idx*4 +: 4];
    if (!dig_en[idx] || (blink_mask[idx] && ph)) return 8'h00;
    return {dp_mask[idx], hex_tbl[nib][6:0]};
  endfunction

  function automatic logic [7:0] model_dsn(input int idx);
    logic [7:0] one;
    one = 8'h80;
    return ~(one >> idx);
  endfunction

  // Push the expected outputs for the coming edge, then advance one clock
  task automatic step(input string tag, input bit hand, input int hk);
    exp_t e;
    int ia, ib;
    if (rst || !en) begin
      e.seg_a = 8'h00; e.dsn_a = 8'hFF; e.fd_a = 1'b0;
      e.seg_b = 8'h00; e.dsn_b = 8'hFF; e.fd_b = 1'b0;
    end else begin
      ia = cyc % 8;
      e.seg_a = model_seg(ia, ((cyc / 8) % 2) == 1);
      e.dsn_a = model_dsn(ia);
      e.fd_a  = (cyc % 8) == 7;
      ib = (cyc / 4) % 8;
      e.seg_b = model_seg(ib, ((cyc / 500) % 2) == 1);
      e.dsn_b = model_dsn(ib);
      e.fd_b  = (cyc % 32) == 31;
      if (hand) begin
        e.seg_a = h_seg[hk];
        e.dsn_a = h_dsn[hk];
        e.fd_a  = (hk == 7);
      end
    end
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst || !en) cyc = 0;
    else cyc++;
  endtask

  // Monitor: one expected entry per clock, compared away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, "_seg_a"}, seg_a, e.seg_a);
      check({e.tag, "_dsn_a"}, dsn_a, e.dsn_a);
      check({e.tag, "_fd_a"},  {7'd0, fd_a}, {7'd0, e.fd_a});
      check({e.tag, "_seg_b"}, seg_b, e.seg_b);
      check({e.tag, "_dsn_b"}, dsn_b, e.dsn_b);
      check({e.tag, "_fd_b"},  {7'd0, fd_b}, {7'd0, e.fd_b});
    end
  end

  initial begin
    int wait_cnt;
    rst = 1'b1; en = 1'b0;
    digits = 32'h30250001; dig_en = 8'hFF; blink_mask = 8'h00; dp_mask = 8'h00;

    for (int i = 0; i < 3; i++) step("reset", 1'b0, 0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) step("idle", 1'b0, 0);

    en = 1'b1;
    for (int i = 0; i < 8; i++) step("frame8", 1'b1, i);
    for (int i = 0; i < 32; i++) step("scan", 1'b0, 0);

    en = 1'b0;
    for (int i = 0; i < 2; i++) step("off", 1'b0, 0);
    digits = 32'h3025000A; blink_mask = 8'h01; en = 1'b1;
    for (int i = 0; i < 32; i++) step("blink", 1'b0, 0);

    en = 1'b0;
    step("off2", 1'b0, 0);
    digits = 32'h30250001; blink_mask = 8'h00; dig_en = 8'hFE; dp_mask = 8'h02; en = 1'b1;
    for (int i = 0; i < 16; i++) step("blank_dp", 1'b0, 0);

    dig_en = 8'hFF; dp_mask = 8'h00;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) digits = mid_tbl[i / 3];
      step("midslot", 1'b0, 0);
    end

    en = 1'b0;
    step("off3", 1'b0, 0);
    digits = 32'h30250001; en = 1'b1;
    for (int i = 0; i < 6; i++) step("pre_rst", 1'b0, 0);

    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_seg_a", seg_a, 8'h00);
    check("async_rst_dsn_a", dsn_a, 8'hFF);
    check("async_rst_fd_b", {7'd0, fd_b}, 8'h00);
    check("async_rst_dsn_b", dsn_b, 8'hFF);
    cyc = 0;
    for (int i = 0; i < 2; i++) step("in_rst", 1'b0, 0);
    rst = 1'b0; en = 1'b0;
    step("post_rst_off", 1'b0, 0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) step("restart", 1'b1, i);

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 5) begin
      @(posedge clk);
      wait_cnt++;
    end
    #6;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 1..16.
REQ-002 SHALL have parameter SCAN_DIV, default 1: clk cycles per digit slot, legal range >= 1.
REQ-003 SHALL have parameter BLINK_HALF, default 500: clk cycles per blink half-period, legal range >= 1.
REQ-004 SHALL have port clk  input  1  single clock, nominal 1 kHz.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  display enable; 0 means display off.
REQ-007 SHALL have port digits  input  4*NUM_DIGITS  hex nibble per digit; digit i uses bits [4i+3:4i].
REQ-008 SHALL have port dig_en  input  NUM_DIGITS  per-digit enable; 0 blanks the digit.
REQ-009 SHALL have port blink_mask  input  NUM_DIGITS  1 makes the digit blink.
REQ-010 SHALL have port dp_mask  input  NUM_DIGITS  1 lights the decimal point of the digit.
REQ-011 SHALL have port segled  output  8  segment drive, active-high; bit7 = dp, bits6..0 = g..a.
REQ-012 SHALL have port DSN  output  NUM_DIGITS  digit select, active-low one-cold.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 Digit slot i SHALL drive DSN bit NUM_DIGITS-1-i low and all other DSN bits high, so digit 0 is the leftmost digit.
REQ-015 Internal registers SHALL be idx (width clog2(NUM_DIGITS), minimum 1), div_cnt (0..SCAN_DIV-1), blink_cnt (0..BLINK_HALF-1) and blink_ph.
REQ-016 On every clk edge with en=1, segled and DSN SHALL load the pattern of digit idx as it was before that edge (registered, 1-cycle latency from the inputs).
REQ-017 On every clk edge with en=1, div_cnt SHALL increment; on reaching SCAN_DIV-1 it SHALL wrap to 0 and idx SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-018 Each digit SHALL be shown for exactly SCAN_DIV consecutive cycles, in order 0..NUM_DIGITS-1.
REQ-019 Segment pattern SHALL use the hex table:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-020 segled[7] SHALL equal dp_mask[idx] unless the digit is blanked.
REQ-021 A digit SHALL be blanked (segled=00, DSN still selects that slot) when dig_en[idx]=0, or when blink_mask[idx]=1 and blink_ph=1.
REQ-022 With en=1, blink_cnt SHALL count every cycle and toggle blink_ph on wrap from BLINK_HALF-1 to 0.
REQ-023 frame_done SHALL be registered high for exactly the edge on which idx wraps from NUM_DIGITS-1 to 0, and low otherwise.
REQ-024 On any edge with en=0: segled=00, DSN all ones, frame_done=0, and idx, div_cnt, blink_cnt, blink_ph all cleared to 0.
REQ-025 On the first edge after en rises, the block SHALL show digit 0 in unblinked phase.
REQ-026 Changes to digits, dig_en, blink_mask or dp_mask mid-slot SHALL appear on the next edge, with no effect on scan timing.
REQ-027 With NUM_DIGITS=1, idx SHALL stay 0 and frame_done SHALL pulse every SCAN_DIV cycles.

Reset
REQ-028 While rst=1, regardless of clk, the block SHALL hold segled=00, DSN all ones, frame_done=0, and idx, div_cnt, blink_cnt, blink_ph at 0.
REQ-029 A reset asserted mid-scan SHALL abort the scan; after release, scanning SHALL restart at digit 0 on the first edge with en=1.

Structure
REQ-030 The hex segment table, the blank pattern constant and the digit-count limit SHALL reside in shared package seg_pkg.
REQ-031 Hex-to-segment decoding SHALL be one combinational sub-module, seg_decode (4-bit in, 7-bit out).
REQ-032 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-033 NUM_DIGITS=8, SCAN_DIV=1, en=1, digits=0x3_0_2_5_0_0_0_1 (digit7..0), dig_en=FF -> DSN sequence 7F,BF,DF,EF,F7,FB,FD,FE; segled 06,3F,3F,3F,6D,5B,3F,4F; frame_done high on the FE edge.
REQ-034 SCAN_DIV=4 -> each DSN value is held for exactly 4 cycles; frame_done period is 32 cycles.
REQ-035 BLINK_HALF=8, blink_mask=01, digit0=A -> digit 0 shows 77 for 8 cycles, then 00 for 8 cycles; other digits are unaffected.
REQ-036 dig_en=FE, dp_mask=02 -> digit 0 slot gives segled=00 with DSN=7F; digit 1 slot gives segled bit7=1.
REQ-037 rst pulse during digit 5, then en toggled 1->0->1 -> outputs are 00/FF immediately; the first enabled edge shows DSN=7F.
